reg_write_sequencer: RTL and testbench
======================================

# reg_write_sequencer

Write-side controller for a bank of `abstract_register` instances. It accepts register write requests from the control unit through a valid/ready handshake and queues them in a small FIFO. Each request drives a one-cycle `load` pulse and a shared `data` bus into the target register. One cycle later it reads back that register's `current` value and reports any mismatch. It sits between the instruction decoder and the register bank of the 18-bit CPU.

## Interface
Parameters:
- `WIDTH`, 8, data width of each register.
- `NUM_REGS`, 4, number of registers driven; must be a power of two, ≥ 2.
- `DEPTH`, 4, request FIFO depth; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  request can be accepted.
- `req_addr`  in  log2(NUM_REGS)  target register index.
- `req_data`  in  WIDTH  value to write.
- `load`  out  NUM_REGS  one-hot load strobes to the registers.
- `data`  out  WIDTH  shared write data bus.
- `current_bus`  in  NUM_REGS*WIDTH  read-back values; register i occupies bits [i*WIDTH +: WIDTH].
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `err`  out  1  one-cycle pulse on a read-back mismatch.
- `err_addr`  out  log2(NUM_REGS)  address of the last mismatch; held until the next mismatch.
- `err_count`  out  8  number of mismatches, saturating at 255.

## Operation
- **Handshake.** `req_ready = !full && !reset` (combinational). A request is accepted on any edge where `req_valid && req_ready`, and its {addr, data} is pushed into the FIFO. Requests are served in FIFO order.
- **State machine.** Registered state, three states: IDLE, LOAD, CHECK.
  - IDLE: if the FIFO is non-empty, pop the head into the hold registers (`h_addr`, `h_data`) and go to LOAD. Otherwise stay in IDLE.
  - LOAD: `load = 1 << h_addr` and `data = h_data` for exactly one cycle, then go to CHECK.
  - CHECK: compare `current_bus[h_addr]` with `h_data`. On mismatch, pulse `err` in the next cycle, latch `err_addr = h_addr`, and increment `err_count` (saturating). Then:
    - if the FIFO is non-empty, pop and go directly to LOAD;
    - otherwise go to IDLE.
- **Outputs outside LOAD.** `load` is all zeros in every state except LOAD. `data` holds its last driven value.
- **Simultaneous push and pop.** Both are allowed in the same cycle; occupancy is unchanged. Pushing into a full FIFO is impossible because `req_ready` is 0.
- **Read-pointer wrap.** Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit or a count.
- **Reset values.** While `reset` is high at an edge:
  - FIFO is emptied; state → IDLE;
  - `load` = 0, `data` = 0;
  - `err` = 0, `err_addr` = 0, `err_count` = 0;
  - `busy` = 0.
  - A reset in the middle of an operation discards the in-flight write and all queued writes, and no `load` pulse follows. A write whose `load` had already been issued is not checked.

## Timing
- Request accepted at edge E0, FSM idle and FIFO empty: pop at E1; `load` is high during the cycle E1–E2; the register captures at E2; compare at E3; `err` (if any) is high during the cycle E3–E4.
- Sustained throughput: one write per 2 cycles (LOAD → CHECK → LOAD …).
- `busy` is registered. It is high from the cycle after E0 until the cycle after the final CHECK with the FIFO empty.
- `err_count` updates on the same edge as `err`.

## Test plan
- **Single write.** After reset, write addr=2, data=0xA5. Expect:
  - `load` = 4'b0100 for exactly one cycle with `data` = 0xA5;
  - `current_bus` slice 2 = 0xA5;
  - `err` stays 0; `busy` returns to 0.
- **Back-to-back burst.** Write {0:0x11, 1:0x22, 2:0x33, 3:0x44} on consecutive cycles. Expect:
  - `load` pulses 0001, 0010, 0100, 1000, spaced 2 cycles apart, with matching data;
  - `req_ready` never drops, since DEPTH = 4 absorbs the burst.
- **FIFO full.** Hold `req_valid` for 7 writes. Expect `req_ready` = 0 once 4 entries are queued. No request is lost or duplicated, and the order is preserved.
- **Mismatch.** Force register 1 to ignore `load`, then write 0x3C to addr 1. Expect:
  - `err` is a one-cycle pulse at E3;
  - `err_addr` = 1, `err_count` = 1;
  - a second failing write gives `err_count` = 2.
- **Reset mid-operation.** Queue 3 writes, then assert `reset` during the first LOAD cycle. Expect:
  - no further `load` pulses;
  - `busy` = 0, `err_count` = 0, and `req_ready` = 1 after reset is released.
- **Saturation.** Force 260 mismatching writes. Expect `err_count` = 255 (no wrap).

Source files
------------

// File: rtl/reg_write_sequencer.sv
// Write-side sequencer for a register bank: queues write requests, pulses the
// target register's load strobe, then reads the register back and flags mismatches.
module reg_write_sequencer #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [$clog2(NUM_REGS)-1:0]   req_addr,
  input  logic [WIDTH-1:0]              req_data,
  output logic [NUM_REGS-1:0]           load,
  output logic [WIDTH-1:0]              data,
  input  logic [NUM_REGS*WIDTH-1:0]     current_bus,
  output logic                          busy,
  output logic                          err,
  output logic [$clog2(NUM_REGS)-1:0]   err_addr,
  output logic [7:0]                    err_count
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + WIDTH;
  localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0]       PTR_ONE  = PW'(1);
  localparam logic [NUM_REGS-1:0] LOAD_ONE = NUM_REGS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [EW-1:0]       fifo_q [DEPTH];
  logic [EW-1:0]       fifo_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       h_addr_q, h_addr_d;
  logic [WIDTH-1:0]    h_data_q, h_data_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                push_s;
  logic                pop_s;
  logic [EW-1:0]       head_s;
  logic [WIDTH-1:0]    readback_s;

  assign req_ready  = (count_q != FULL_CNT) && !reset;
  assign readback_s = current_bus[int'(h_addr_q) * WIDTH +: WIDTH];
  assign head_s     = fifo_q[rd_ptr_q];

  assign load      = load_q;
  assign data      = data_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

  // Next-state logic for the FIFO, the sequencing FSM and all registered outputs.
  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    h_addr_d    = h_addr_q;
    h_data_d    = h_data_q;
    data_d      = data_q;
    load_d      = {NUM_REGS{1'b0}};
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    state_d     = state_q;
    pop_s       = 1'b0;
    push_s      = req_valid && req_ready;

    case (state_q)
      ST_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          pop_s   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (readback_s != h_data_q) begin
          err_d      = 1'b1;
          err_addr_d = h_addr_q;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          err_d = 1'b0;
        end
        // Chain straight into the next write so a busy queue sustains one write per two cycles.
        if (count_q != {CW{1'b0}}) begin
          pop_s   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop_s) begin
      h_addr_d = head_s[EW-1:WIDTH];
      h_data_d = head_s[WIDTH-1:0];
      load_d   = LOAD_ONE << head_s[EW-1:WIDTH];
      data_d   = head_s[WIDTH-1:0];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      fifo_d[wr_ptr_q] = {req_addr, req_data};
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    count_d = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    busy_d  = (count_d != {CW{1'b0}}) || (state_d != ST_IDLE);
  end

  // Control and output registers; reset discards queued and in-flight writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      h_addr_q    <= {AW{1'b0}};
      h_data_q    <= {WIDTH{1'b0}};
      load_q      <= {NUM_REGS{1'b0}};
      data_q      <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= {AW{1'b0}};
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      h_addr_q    <= h_addr_d;
      h_data_q    <= h_data_d;
      load_q      <= load_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // Request storage; contents are don't-care while the occupancy count says empty.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Self-checking bench for reg_write_sequencer: a register-bank model feeds
// current_bus, and a scoreboard of accepted writes is checked against load pulses.
`timescale 1ns/1ps
module tb_reg_write_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_data = 8'h00;
  logic [3:0] load;
  logic [7:0] data;
  logic [31:0] current_bus;
  logic       busy;
  logic       err;
  logic [1:0] err_addr;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] ignore_mask = 4'b0000;
  logic [9:0] exp_q [$];
  int         load_cyc [$];
  logic       rst_at_edge = 1'b1;
  logic [1:0] pend_m = 2'b00;
  logic [1:0] pend_a0 = 2'd0;
  logic [1:0] pend_a1 = 2'd0;
  logic [7:0] exp_cnt = 8'h00;
  logic [1:0] exp_eaddr = 2'd0;

  reg_write_sequencer #(.WIDTH(8), .NUM_REGS(4), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .load        (load),
    .data        (data),
    .current_bus (current_bus),
    .busy        (busy),
    .err         (err),
    .err_addr    (err_addr),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  assign current_bus = {regs[3], regs[2], regs[1], regs[0]};

  // Register bank model; a register in ignore_mask refuses its load strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load[i] && !ignore_mask[i]) regs[i] <= data;
    end
    rst_at_edge <= reset;
  end

  // Monitor: pops the scoreboard on every load pulse and tracks expected err/err_count.
  always @(negedge clk) begin
    logic [9:0] e;
    logic       exp_err;
    logic       m;
    logic [1:0] a;
    cyc = cyc + 1;
    if (rst_at_edge) begin
      exp_q.delete();
      pend_m = 2'b00;
      exp_cnt = 8'h00;
      exp_eaddr = 2'd0;
      checks++;
      if (load !== 4'h0 || data !== 8'h00 || busy !== 1'b0 || err !== 1'b0 ||
          err_count !== 8'h00 || err_addr !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: load=%b data=%h busy=%b err=%b err_addr=%0d err_count=%0d, required all zero",
                 load, data, busy, err, err_addr, err_count);
      end
    end else begin
      exp_err = pend_m[1];
      if (exp_err) begin
        exp_eaddr = pend_a1;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
      m = 1'b0;
      a = 2'd0;
      if (load !== 4'h0) begin
        load_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: load=%b data=%h, required no pulse", load, data);
        end else begin
          e = exp_q.pop_front();
          if (load !== (4'b0001 << e[9:8]) || data !== e[7:0]) begin
            errors++;
            $display("FAIL load_pulse: load=%b data=%h, required load=%b data=%h",
                     load, data, (4'b0001 << e[9:8]), e[7:0]);
          end
          a = e[9:8];
          m = ignore_mask[a] && (regs[a] != e[7:0]);
        end
      end
      pend_m  = {pend_m[0], m};
      pend_a1 = pend_a0;
      pend_a0 = a;
      checks++;
      if (err !== exp_err || err_count !== exp_cnt || (exp_err && err_addr !== exp_eaddr)) begin
        errors++;
        $display("FAIL err_track: err=%b err_addr=%0d err_count=%0d, required err=%b err_addr=%0d err_count=%0d",
                 err, err_addr, err_count, exp_err, exp_eaddr, exp_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] a, input logic [7:0] d);
    int guard = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (req_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL send_timeout: req_ready=%b, required 1 within 100 cycles", req_ready);
    end else begin
      exp_q.push_back({a, d});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && guard < 2000) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL %s_idle: busy=%b pending=%0d, required busy=0 pending=0", tag, busy, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || load !== 4'h0) begin
      errors++;
      $display("FAIL after_reset: req_ready=%b busy=%b load=%b, required 1 0 0000", req_ready, busy, load);
    end
  endtask

  task automatic test_single_write();
    send(2'd2, 8'hA5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b, required 1", busy);
    end
    wait_idle("single");
    checks++;
    if (current_bus[23:16] !== 8'hA5 || err_count !== 8'h00) begin
      errors++;
      $display("FAIL single_readback: reg2=%h err_count=%0d, required a5 0", current_bus[23:16], err_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      send(2'(i), vals[i]);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL burst_ready: req_ready=%b after write %0d, required 1", req_ready, i);
      end
    end
    wait_idle("burst");
    checks++;
    if (load_cyc.size() != 4) begin
      errors++;
      $display("FAIL burst_pulses: count=%0d, required 4", load_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (load_cyc[i] - load_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL burst_spacing: gap=%0d, required 2", load_cyc[i] - load_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 7; i++) send(2'(i % 4), 8'h50 + 8'(i));
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: req_ready=%b with 4 queued, required 0", req_ready);
    end
    send(2'd3, 8'h57);
    wait_idle("full");
  endtask

  task automatic test_mismatch();
    ignore_mask = 4'b0010;
    send(2'd1, 8'h3C);
    wait_idle("mismatch1");
    checks++;
    if (err_count !== 8'd1 || err_addr !== 2'd1) begin
      errors++;
      $display("FAIL mismatch_first: err_count=%0d err_addr=%0d, required 1 1", err_count, err_addr);
    end
    send(2'd1, 8'hC3);
    wait_idle("mismatch2");
    checks++;
    if (err_count !== 8'd2 || err_addr !== 2'd1) begin
      errors++;
      $display("FAIL mismatch_second: err_count=%0d err_addr=%0d, required 2 1", err_count, err_addr);
    end
    ignore_mask = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    send(2'd0, 8'h01);
    send(2'd2, 8'h02);
    send(2'd3, 8'h03);
    while (load === 4'h0 && guard < 20) begin
      tick();
      guard++;
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b0 || err_count !== 8'h00 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: busy=%b err_count=%0d req_ready=%b, required 0 0 1", busy, err_count, req_ready);
    end
  endtask

  task automatic test_saturation();
    ignore_mask = 4'b1000;
    for (int i = 0; i < 260; i++) send(2'd3, regs[3] ^ 8'hFF);
    wait_idle("saturation");
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturation: err_count=%0d, required 255", err_count);
    end
    ignore_mask = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_fifo_full();
    test_mismatch();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
